bsg_mesh_traffic_gen: RTL and testbench

BSG_MESH_TRAFFIC_GEN -- requirements
Module: bsg_mesh_traffic_gen

---
 rtl/bsg_mesh_traffic_pkg.sv | 25 ++
 rtl/bsg_mesh_traffic_seq.sv | 40 ++++
 rtl/bsg_mesh_traffic_gen.sv | 127 ++++++++++++
 tb/tb_bsg_mesh_traffic_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_mesh_traffic_pkg.sv
// rtl/bsg_mesh_traffic_pkg.sv - shared types for the mesh traffic generator
package bsg_mesh_traffic_pkg;

    typedef enum logic [1:0] {
        e_idle,
        e_send,
        e_done
    } bsg_mesh_traffic_state_e;

    localparam int pkt_data_width_lp = 4;
    localparam int pkt_y_width_lp    = 2;
    localparam int pkt_x_width_lp    = 2;

    // Destination x sits in the LSBs so routers can steer on the low bits first.
    typedef struct packed {
        logic [pkt_data_width_lp-1:0] payload;
        logic [pkt_y_width_lp-1:0]    y;
        logic [pkt_x_width_lp-1:0]    x;
    } bsg_mesh_traffic_pkt_s;

    function automatic int safe_width(input int els);
        return (els > 1) ? $clog2(els) : 1;
    endfunction

endpackage

// File: rtl/bsg_mesh_traffic_seq.sv
// rtl/bsg_mesh_traffic_seq.sv - destination index / round two-level wrap counter
module bsg_mesh_traffic_seq
    import bsg_mesh_traffic_pkg::*;
#(
    parameter int els_p    = 16,
    parameter int rounds_p = 2,
    localparam int d_width_lp = safe_width(els_p),
    localparam int r_width_lp = safe_width(rounds_p)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clear_i,
    input  logic                  up_i,
    output logic [d_width_lp-1:0] d_o,
    output logic                  last_o
);

    logic [r_width_lp-1:0] round_r;
    logic                  d_last;
    logic                  round_last;

    assign d_last     = (d_o == d_width_lp'(els_p - 1));
    assign round_last = (round_r == r_width_lp'(rounds_p - 1));
    assign last_o     = d_last & round_last;

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            d_o     <= '0;
            round_r <= '0;
        end else if (up_i) begin
            if (d_last) begin
                d_o     <= '0;
                round_r <= round_last ? '0 : round_r + r_width_lp'(1);
            end else begin
                d_o <= d_o + d_width_lp'(1);
            end
        end
    end

endmodule

// File: rtl/bsg_mesh_traffic_gen.sv
// rtl/bsg_mesh_traffic_gen.sv - sweeps all mesh tiles with packets and checks received traffic
module bsg_mesh_traffic_gen
    import bsg_mesh_traffic_pkg::*;
#(
    parameter int data_width_p   = 4,
    parameter int x_cord_width_p = 2,
    parameter int y_cord_width_p = 2,
    parameter int num_x_p        = 4,
    parameter int num_y_p        = 4,
    parameter int num_rounds_p   = 2,
    localparam int pkt_width_lp   = data_width_p + y_cord_width_p + x_cord_width_p,
    localparam int tiles_lp       = num_x_p * num_y_p,
    localparam int count_width_lp = $clog2(tiles_lp * num_rounds_p + 1),
    localparam int d_width_lp     = safe_width(tiles_lp)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    input  logic                      start_i,
    output logic                      v_o,
    output logic [pkt_width_lp-1:0]   data_o,
    input  logic                      ready_and_i,
    input  logic                      v_i,
    input  logic [pkt_width_lp-1:0]   data_i,
    output logic                      yumi_o,
    input  logic                      rx_stall_i,
    output logic [count_width_lp-1:0] sent_o,
    output logic [count_width_lp-1:0] recv_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o
);

    bsg_mesh_traffic_state_e state_r;
    logic [d_width_lp-1:0]   d;
    logic                    last;
    logic                    xfer;
    logic                    launch;
    logic [31:0]             own_id;
    logic [31:0]             d_ext;

    assign own_id = 32'(my_y_i) * 32'(num_x_p) + 32'(my_x_i);
    assign d_ext  = 32'(d);

    assign v_o    = (state_r == e_send);
    assign busy_o = (state_r == e_send);
    assign done_o = (state_r == e_done);
    assign xfer   = v_o & ready_and_i;
    assign launch = start_i & (state_r != e_send);

    // data_o is a pure function of d, so it holds naturally while stalled.
    assign data_o = {data_width_p'(own_id ^ d_ext),
                     y_cord_width_p'(d_ext / 32'(num_x_p)),
                     x_cord_width_p'(d_ext % 32'(num_x_p))};

    bsg_mesh_traffic_seq #(
        .els_p    (tiles_lp),
        .rounds_p (num_rounds_p)
    ) seq (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (launch),
        .up_i    (xfer),
        .d_o     (d),
        .last_o  (last)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_idle;
            sent_o  <= '0;
        end else begin
            case (state_r)
                e_idle, e_done: begin
                    if (start_i) begin
                        state_r <= e_send;
                        sent_o  <= '0;
                    end
                end
                e_send: begin
                    if (xfer) begin
                        sent_o <= sent_o + count_width_lp'(1);
                        if (last) begin
                            state_r <= e_done;
                        end
                    end
                end
                default: state_r <= e_idle;
            endcase
        end
    end

    logic [x_cord_width_p-1:0] rx_x;
    logic [y_cord_width_p-1:0] rx_y;
    logic [data_width_p-1:0]   rx_payload;
    logic                      addr_err;
    logic                      payload_err;

    assign rx_x       = data_i[x_cord_width_p-1:0];
    assign rx_y       = data_i[x_cord_width_p+y_cord_width_p-1:x_cord_width_p];
    assign rx_payload = data_i[pkt_width_lp-1:x_cord_width_p+y_cord_width_p];
    assign addr_err   = (rx_x != my_x_i) || (rx_y != my_y_i);
    assign yumi_o     = v_i & ~rx_stall_i & ~reset_i;

    // A narrow payload cannot carry every tile id, so the range check only applies when it can.
    if (2 ** data_width_p >= tiles_lp) begin : g_payload_chk
        assign payload_err = ((32'(rx_payload) ^ own_id) >= 32'(tiles_lp));
    end else begin : g_payload_nochk
        assign payload_err = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            recv_o  <= '0;
            error_o <= 1'b0;
        end else if (yumi_o) begin
            if (recv_o != '1) begin
                recv_o <= recv_o + count_width_lp'(1);
            end
            if (addr_err || payload_err) begin
                error_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bsg_mesh_traffic_gen.sv
// tb/tb_bsg_mesh_traffic_gen.sv - scoreboard bench for bsg_mesh_traffic_gen
module tb_bsg_mesh_traffic_gen;
    import bsg_mesh_traffic_pkg::*;

    localparam int W = 8;
    localparam int C = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start, ready_and, rx_stall, inj_v, loop_en;
    logic [1:0]   my_x, my_y;
    logic [W-1:0] inj_data;
    logic         v_o, yumi_o, busy_o, done_o, error_o, v_i;
    logic [W-1:0] data_o, data_i;
    logic [C-1:0] sent_o, recv_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    int         lat;
    bsg_mesh_traffic_pkt_s inj_pkt;

    // The mesh only hands back packets addressed to this tile.
    assign v_i    = loop_en ? (v_o & ready_and & (data_o[3:0] == {my_y, my_x})) : inj_v;
    assign data_i = loop_en ? data_o : inj_data;

    bsg_mesh_traffic_gen dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .my_x_i      (my_x),
        .my_y_i      (my_y),
        .start_i     (start),
        .v_o         (v_o),
        .data_o      (data_o),
        .ready_and_i (ready_and),
        .v_i         (v_i),
        .data_i      (data_i),
        .yumi_o      (yumi_o),
        .rx_stall_i  (rx_stall),
        .sent_o      (sent_o),
        .recv_o      (recv_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] pkt(input int d, input int own);
        logic [3:0] p;
        logic [1:0] y;
        logic [1:0] x;
        p = 4'((own ^ d) & 15);
        y = 2'(d / 4);
        x = 2'(d % 4);
        return {p, y, x};
    endfunction

    always @(negedge clk) begin
        if (!reset && v_o === 1'b1 && ready_and === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("tx_unexpected", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("tx_data", 32'(data_o), 32'(mon_exp));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        for (int r = 0; r < 2; r++)
            for (int d = 0; d < 16; d++)
                exp_q.push_back(pkt(d, 9));
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done_o && n < 200) begin
            step();
            n++;
        end
        check("done_reached", 32'(done_o), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; ready_and = 1'b1; rx_stall = 1'b0;
        loop_en = 1'b0; my_x = 2'd1; my_y = 2'd2;
        inj_v = 1'b1; inj_data = 8'h09;
        step(); step();
        check("rst_v", 32'(v_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_sent", 32'(sent_o), 0);
        check("rst_recv", 32'(recv_o), 0);
        check("rst_error", 32'(error_o), 0);
        check("rst_yumi", 32'(yumi_o), 0);
        reset = 1'b0; inj_v = 1'b0;
        step();
        check("post_rst_v", 32'(v_o), 0);
        check("post_rst_done", 32'(done_o), 0);

        // Full run with loopback
        loop_en = 1'b1;
        start_run();
        check("first_data", 32'(data_o), 32'h90);
        check("first_v", 32'(v_o), 1);
        check("first_busy", 32'(busy_o), 1);
        wait_done(lat);
        check("done_latency", lat, 32);
        check("run1_sent", 32'(sent_o), 32);
        check("run1_recv", 32'(recv_o), 2);
        check("run1_error", 32'(error_o), 0);
        check("run1_v_off", 32'(v_o), 0);
        check("run1_q_empty", exp_q.size(), 0);

        // Backpressure on d=3, plus a start pulse that must be ignored
        start_run();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (data_o != 8'hA3 && n < 20) begin
            step();
            n++;
        end
        check("stall_reach_d3", 32'(data_o), 32'hA3);
        ready_and = 1'b0;
        check("stall_sent_before", 32'(sent_o), 3);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_v", 32'(v_o), 1);
            check("stall_data", 32'(data_o), 32'hA3);
            check("stall_sent", 32'(sent_o), 3);
        end
        ready_and = 1'b1;
        wait_done(lat);
        check("run2_sent", 32'(sent_o), 32);
        check("run2_recv", 32'(recv_o), 4);
        check("run2_q_empty", exp_q.size(), 0);

        // Misaddressed packet sets a sticky error
        loop_en = 1'b0;
        check("err_before", 32'(error_o), 0);
        inj_pkt = '{payload: 4'h0, y: 2'd0, x: 2'd0};
        inj_data = inj_pkt;
        inj_v = 1'b1;
        step();
        inj_v = 1'b0;
        check("err_set", 32'(error_o), 1);
        check("err_recv", 32'(recv_o), 5);
        step();
        check("err_hold", 32'(error_o), 1);
        loop_en = 1'b1;
        start_run();
        check("err_after_start", 32'(error_o), 1);
        wait_done(lat);
        check("err_sticky_end", 32'(error_o), 1);
        check("run3_recv", 32'(recv_o), 7);

        // Reset mid-run abandons the sweep
        start_run();
        n = 0;
        while (sent_o != 10 && n < 40) begin
            step();
            n++;
        end
        check("mid_sent10", 32'(sent_o), 10);
        reset = 1'b1;
        ready_and = 1'b0;
        step();
        check("mid_rst_v", 32'(v_o), 0);
        check("mid_rst_sent", 32'(sent_o), 0);
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_recv", 32'(recv_o), 0);
        check("mid_rst_error", 32'(error_o), 0);
        reset = 1'b0;
        ready_and = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_restart_v", 32'(v_o), 0);
        end
        start_run();
        check("restart_d0", 32'(data_o), 32'h90);
        wait_done(lat);
        check("run4_sent", 32'(sent_o), 32);
        check("run4_recv", 32'(recv_o), 2);
        check("run4_q_empty", exp_q.size(), 0);

        // Receive stall, then simultaneous send and receive
        loop_en = 1'b0;
        inj_data = 8'h09;
        inj_v = 1'b1;
        rx_stall = 1'b1;
        step();
        check("rxstall_yumi", 32'(yumi_o), 0);
        check("rxstall_recv", 32'(recv_o), 2);
        step();
        check("rxstall_recv_hold", 32'(recv_o), 2);
        inj_v = 1'b0;
        rx_stall = 1'b0;
        start_run();
        check("simul_sent_pre", 32'(sent_o), 0);
        inj_v = 1'b1;
        #1;
        check("simul_yumi", 32'(yumi_o), 1);
        step();
        inj_v = 1'b0;
        check("simul_sent", 32'(sent_o), 1);
        check("simul_recv", 32'(recv_o), 3);
        wait_done(lat);
        check("run5_sent", 32'(sent_o), 32);
        check("run5_recv", 32'(recv_o), 3);
        check("run5_error", 32'(error_o), 0);
        check("run5_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
